lru_nway: RTL
=============

# lru_nway

Parametrised N-way true-LRU replacement tracker for the cache subsystem, successor to the fixed 4-way age-based tracker. Keeps one age permutation per set, updates it on hits/fills, supports explicit invalidate-demote, and selects a victim for a queried set that honours per-way valid and lock masks. Sits beside the tag array; the cache controller drives updates on the access pipeline and reads the victim combinationally during miss handling.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- SET_BITS, `INDEX_WIDTH, set index width (SETS = 2**SET_BITS)
- WAY_BITS, $clog2(WAYS), derived local parameter; not overridable

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- update_en  input  1  touch accessed_way in set_idx (hit or fill)
- set_idx  input  SET_BITS  set for touch
- accessed_way  input  WAY_BITS  way touched
- inv_en  input  1  demote inv_way in inv_idx to oldest
- inv_idx  input  SET_BITS  set for invalidate
- inv_way  input  WAY_BITS  way demoted
- query_idx  input  SET_BITS  set queried for victim
- valid_mask  input  WAYS  per-way valid bits of queried set (from tag array)
- lock_mask  input  WAYS  per-way lock bits; 1 = never chosen as victim
- victim_way  output  WAY_BITS  selected replacement way
- victim_valid  output  1  1 = victim_way usable; 0 = every way locked

## Operation
- State: age[s][w], WAY_BITS each; in every set the ages form a permutation of 0..WAYS-1 (0 = MRU, WAYS-1 = LRU). Invariant holds after reset and after every cycle.
- Reset: age[s][w] = w for every set (way WAYS-1 oldest, way 0 MRU).
- Touch (update_en): a = age[set_idx][accessed_way]; accessed way -> 0; ways with age < a increment; ways with age > a unchanged. Touching MRU way: no change.
- Invalidate (inv_en): a = age[inv_idx][inv_way]; inv_way -> WAYS-1; ways with age > a decrement. Invalidating LRU way: no change.
- Both enables, different sets: both applied same edge.
- Both enables, same set: touch applied, invalidate dropped.
- Victim select (combinational from current state of query_idx), first rule that matches:
  1. Any way with valid_mask=0 and lock_mask=0: lowest-index such way.
  2. Otherwise the unlocked way with the greatest age.
  3. All ways locked: victim_valid=0, victim_way=0.
- victim_valid=1 in cases 1 and 2. Lock/valid masks never modify age state.
- Out-of-range accessed_way/inv_way impossible (WAYS power of two); no checking.

## Timing
- Touch/invalidate: state changes at the rising edge where enable is sampled high; visible on victim outputs in the following cycle.
- Read-during-write: query_idx == set_idx/inv_idx in the update cycle returns pre-update victim.
- Victim path purely combinational from query_idx, valid_mask, lock_mask and state; zero-cycle latency.
- Reset asserted mid-operation: all sets return to reset ages immediately (asynchronous); updates sampled while reset is high are discarded. Outputs under reset with masks all-valid/unlocked: victim_way=WAYS-1, victim_valid=1.
- No handshake; one touch and one invalidate accepted every cycle, back-to-back to same set allowed (each uses state left by previous edge).

## Test plan
- WAYS=4, set 3: after reset touch ways 1,2,3 -> victim_way=0; repeat for sets 12, 47, 63, 127 with sequences leaving victims 1, 2, 3 -> matching victim each.
- WAYS=8, set 5: touch 0..7 in order -> victim 0; touch 0 -> victim 1; invalidate way 6 -> victim 6, way 1 age becomes 6.
- WAYS=4 reset state, lock_mask=4'b1000 -> victim 2; lock_mask=4'b1111 -> victim_valid=0, victim_way=0.
- valid_mask=4'b1010, lock_mask=0 -> victim 0; lock_mask=4'b0001 -> victim 2.
- Same cycle touch way 3 and invalidate way 0 on set 9 -> only touch applied (victim 2 afterward); on sets 9 and 10 -> both applied (set 10 victim 0).
- Assert reset between touches on set 20 -> victim 3 next cycle; random 10k touch/invalidate run with scoreboard checking permutation invariant and victim every cycle.

Source files
------------

// File: rtl/lru_nway.sv
// True-LRU age tracker per set with touch/invalidate updates and masked victim selection.
// Updates land on the clock edge; the victim path is purely combinational from current state.
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 7
`endif

module lru_nway #(
    parameter int  WAYS     = 4,
    parameter int  SET_BITS = `INDEX_WIDTH,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                update_en,
    input  logic [SET_BITS-1:0] set_idx,
    input  logic [WAY_BITS-1:0] accessed_way,
    input  logic                inv_en,
    input  logic [SET_BITS-1:0] inv_idx,
    input  logic [WAY_BITS-1:0] inv_way,
    input  logic [SET_BITS-1:0] query_idx,
    input  logic [WAYS-1:0]     valid_mask,
    input  logic [WAYS-1:0]     lock_mask,
    output logic [WAY_BITS-1:0] victim_way,
    output logic                victim_valid
);

    localparam int SETS = 1 << SET_BITS;

    logic [WAY_BITS-1:0] age_q [SETS][WAYS];
    logic [WAY_BITS-1:0] age_d [SETS][WAYS];

    logic [WAY_BITS-1:0] touch_age;
    logic [WAY_BITS-1:0] inv_age;
    logic                inv_apply;

    always_comb begin
        age_d     = age_q;
        touch_age = age_q[set_idx][accessed_way];
        inv_age   = age_q[inv_idx][inv_way];
        // A touch and an invalidate aimed at the same set: the touch wins.
        inv_apply = inv_en && !(update_en && (inv_idx == set_idx));

        if (update_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_BITS'(w) == accessed_way) begin
                    age_d[set_idx][w] = '0;
                end else if (age_q[set_idx][w] < touch_age) begin
                    age_d[set_idx][w] = age_q[set_idx][w] + WAY_BITS'(1);
                end
            end
        end

        if (inv_apply) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_BITS'(w) == inv_way) begin
                    age_d[inv_idx][w] = WAY_BITS'(WAYS - 1);
                end else if (age_q[inv_idx][w] > inv_age) begin
                    age_d[inv_idx][w] = age_q[inv_idx][w] - WAY_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_BITS'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    logic                found_free;
    logic [WAY_BITS-1:0] free_way;
    logic [WAY_BITS-1:0] best_age;

    always_comb begin
        found_free   = 1'b0;
        free_way     = '0;
        best_age     = '0;
        victim_way   = '0;
        victim_valid = 1'b0;

        // Descending scan so the lowest-index empty unlocked way is kept.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mask[w] && !lock_mask[w]) begin
                found_free = 1'b1;
                free_way   = WAY_BITS'(w);
            end
        end

        for (int w = 0; w < WAYS; w++) begin
            if (!lock_mask[w] && (!victim_valid || (age_q[query_idx][w] > best_age))) begin
                victim_valid = 1'b1;
                best_age     = age_q[query_idx][w];
                victim_way   = WAY_BITS'(w);
            end
        end

        if (found_free) begin
            victim_way = free_way;
        end
    end

endmodule
